// File: rtl/disp_pkg.sv
// Shared constants for the display pixel buffer and VRAM controller.
// Holds FIFO sizing and RGB field positions within a 32-bit pixel word.
package disp_pkg;

    localparam int DISP_DEPTH_LOG2 = 9;
    localparam int DISP_BURST_LEN  = 8;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic rgb_t to_rgb(input logic [31:0] w);
        rgb_t p;
        p.r = w[R_LSB +: 8];
        p.g = w[G_LSB +: 8];
        p.b = w[B_LSB +: 8];
        return p;
    endfunction

endpackage

// File: rtl/disp_fifo_mem.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// The array has no reset so it maps onto block RAM.
module disp_fifo_mem #(
    parameter int AW = 9,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/disp_pixbuf.sv
// Display pixel FIFO between the VRAM read channel and the timing block.
// Pixels pop with one-cycle latency; overflow/underflow are sticky.
module disp_pixbuf
    import disp_pkg::*;
#(
    parameter int DEPTH_LOG2 = DISP_DEPTH_LOG2,
    parameter int BURST_LEN  = DISP_BURST_LEN
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic [31:0] RDATA,
    input  logic        RVALID,
    input  logic        RREADY,
    input  logic        RLAST,
    input  logic        VRSTART,
    input  logic        DISPON,
    input  logic        PREN,
    input  logic        CLRERR,
    output logic        BUF_WREADY,
    output logic [7:0]  DSP_R,
    output logic [7:0]  DSP_G,
    output logic [7:0]  DSP_B,
    output logic        DSP_VALID,
    output logic        OVFL,
    output logic        UNFL
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] count;
    logic [PW-1:0] free;
    logic          flush;
    logic          wen;
    logic          ren;
    logic          full;
    logic          empty;
    logic          do_wr;
    logic          do_rd;
    logic          wready_q;
    logic          valid_q;
    logic          ovfl_q;
    logic          unfl_q;
    logic [15:0]   burst_cnt;
    rgb_t          rd_pix;

    assign flush = VRSTART | ~DISPON;
    assign wen   = RVALID & RREADY & DISPON & ~flush;
    assign ren   = PREN & DISPON & ~flush;

    assign count = wptr - rptr;
    assign free  = CAP - count;
    assign full  = (wptr[PW-1] != rptr[PW-1]) &&
                   (wptr[PW-2:0] == rptr[PW-2:0]);
    assign empty = (wptr == rptr);

    // Full blocks the write even if a read frees a slot this cycle.
    assign do_wr = wen & ~full;
    assign do_rd = ren & ~empty;

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            wptr      <= '0;
            rptr      <= '0;
            wready_q  <= 1'b0;
            valid_q   <= 1'b0;
            ovfl_q    <= 1'b0;
            unfl_q    <= 1'b0;
            burst_cnt <= '0;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_wr) wptr <= wptr + 1'b1;
                if (do_rd) rptr <= rptr + 1'b1;
            end
            wready_q <= DISPON && (free >= PW'(BURST_LEN));
            valid_q  <= do_rd;
            ovfl_q   <= (wen & full) | (ovfl_q & ~CLRERR);
            unfl_q   <= (ren & empty) | (unfl_q & ~CLRERR);
            if (flush) begin
                burst_cnt <= '0;
            end else if (RLAST & wen) begin
                burst_cnt <= burst_cnt + 16'd1;
            end
        end
    end

    disp_fifo_mem #(
        .AW (DEPTH_LOG2),
        .DW ($bits(rgb_t))
    ) u_mem (
        .clk   (ACLK),
        .we    (do_wr),
        .waddr (wptr[PW-2:0]),
        .wdata (to_rgb(RDATA)),
        .re    (do_rd),
        .raddr (rptr[PW-2:0]),
        .rdata (rd_pix)
    );

    // Read register holds stale data when idle; gate it to zero.
    assign DSP_R      = valid_q ? rd_pix.r : 8'd0;
    assign DSP_G      = valid_q ? rd_pix.g : 8'd0;
    assign DSP_B      = valid_q ? rd_pix.b : 8'd0;
    assign DSP_VALID  = valid_q;
    assign BUF_WREADY = wready_q;
    assign OVFL       = ovfl_q;
    assign UNFL       = unfl_q;

endmodule

// File: tb/tb_disp_pixbuf.sv
// Directed bench for disp_pixbuf with a FIFO reference model and a
// scoreboard of expected popped pixels.
module tb_disp_pixbuf;

    logic        ACLK = 1'b0;
    logic        ARST = 1'b0;
    logic [31:0] RDATA = '0;
    logic        RVALID = 1'b0;
    logic        RREADY = 1'b0;
    logic        RLAST = 1'b0;
    logic        VRSTART = 1'b0;
    logic        DISPON = 1'b0;
    logic        PREN = 1'b0;
    logic        CLRERR = 1'b0;
    logic        BUF_WREADY;
    logic [7:0]  DSP_R;
    logic [7:0]  DSP_G;
    logic [7:0]  DSP_B;
    logic        DSP_VALID;
    logic        OVFL;
    logic        UNFL;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] q_fifo [$];
    logic [23:0] exp_pix [$];
    logic        m_ovfl = 1'b0;
    logic        m_unfl = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_wready = 1'b0;

    always #5 ACLK = ~ACLK;

    disp_pixbuf dut (
        .ACLK       (ACLK),
        .ARST       (ARST),
        .RDATA      (RDATA),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .RLAST      (RLAST),
        .VRSTART    (VRSTART),
        .DISPON     (DISPON),
        .PREN       (PREN),
        .CLRERR     (CLRERR),
        .BUF_WREADY (BUF_WREADY),
        .DSP_R      (DSP_R),
        .DSP_G      (DSP_G),
        .DSP_B      (DSP_B),
        .DSP_VALID  (DSP_VALID),
        .OVFL       (OVFL),
        .UNFL       (UNFL)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then check outputs.
    task automatic cyc(input logic rst, input logic don, input logic vs,
                       input logic rv, input logic rr, input logic rl,
                       input logic pr, input logic clr,
                       input logic [31:0] d);
        int n;
        logic fl, w, r;
        logic [23:0] p;
        n = q_fifo.size();
        ARST = rst; DISPON = don; VRSTART = vs; RVALID = rv;
        RREADY = rr; RLAST = rl; PREN = pr; CLRERR = clr; RDATA = d;
        if (rst) begin
            q_fifo.delete();
            exp_pix.delete();
            m_ovfl = 1'b0;
            m_unfl = 1'b0;
            exp_valid = 1'b0;
            exp_wready = 1'b0;
        end else begin
            exp_wready = don && ((512 - n) >= 8);
            fl = vs | ~don;
            w = rv & rr & don & ~fl;
            r = pr & don & ~fl;
            exp_valid = 1'b0;
            if (fl) begin
                q_fifo.delete();
            end else begin
                if (r && n > 0) begin
                    exp_pix.push_back(q_fifo.pop_front());
                    exp_valid = 1'b1;
                end
                if (w && n < 512) q_fifo.push_back(d[23:0]);
            end
            m_ovfl = (w && n >= 512) | (m_ovfl & ~clr);
            m_unfl = (r && n == 0) | (m_unfl & ~clr);
        end
        @(posedge ACLK);
        #1;
        chk("dsp_valid", 32'(DSP_VALID), 32'(exp_valid));
        if (DSP_VALID === 1'b1 && exp_pix.size() > 0) begin
            p = exp_pix.pop_front();
            chk("dsp_rgb", {8'h0, DSP_R, DSP_G, DSP_B}, {8'h0, p});
        end else begin
            chk("dsp_rgb_idle", {8'h0, DSP_R, DSP_G, DSP_B}, 32'h0);
        end
        chk("buf_wready", 32'(BUF_WREADY), 32'(exp_wready));
        chk("ovfl", 32'(OVFL), 32'(m_ovfl));
        chk("unfl", 32'(UNFL), 32'(m_unfl));
    endtask

    task automatic wr(input logic [31:0] d, input logic rl);
        cyc(0, 1, 0, 1, 1, rl, 0, 0, d);
    endtask

    task automatic rd();
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 32'h0);
    endtask

    task automatic idle();
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        // Reset, then first cycle out of reset raises BUF_WREADY.
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("rst_wready", 32'(BUF_WREADY), 32'h0);
        idle();
        chk("post_rst_wready", 32'(BUF_WREADY), 32'h1);

        // Eight-beat burst, then eight pops.
        for (int i = 0; i < 8; i++) wr(32'h0011_2233 + i, i == 7);
        for (int i = 0; i < 8; i++) rd();
        chk("last_pixel_b", 32'(DSP_B), 32'h3A);
        idle();

        // Beat without RREADY is not stored.
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 32'hFFAA_BBCC);
        rd();
        chk("rready_gate_unfl", 32'(UNFL), 32'h1);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 32'h0);
        chk("unfl_cleared", 32'(UNFL), 32'h0);

        // Fill to 505: free 7 drops BUF_WREADY; one pop restores it.
        for (int i = 0; i < 505; i++) wr($urandom, (i % 8) == 7);
        idle();
        chk("wready_505", 32'(BUF_WREADY), 32'h0);
        rd();
        idle();
        chk("wready_504", 32'(BUF_WREADY), 32'h1);

        // Flush, then 513 writes with no reads overflow.
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 513; i++) wr($urandom, 0);
        chk("ovfl_513", 32'(OVFL), 32'h1);

        // Write+read while full: read taken, write dropped.
        cyc(0, 1, 0, 1, 1, 0, 1, 0, 32'h00DE_AD01);
        chk("full_rw_valid", 32'(DSP_VALID), 32'h1);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 32'h0);
        chk("ovfl_cleared", 32'(OVFL), 32'h0);

        // Drain 511 words; the next pop underflows.
        for (int i = 0; i < 511; i++) rd();
        rd();
        chk("drain_unfl", 32'(UNFL), 32'h1);
        chk("drain_valid", 32'(DSP_VALID), 32'h0);

        // Set and clear in the same cycle keeps the flag set.
        cyc(0, 1, 0, 0, 0, 0, 1, 1, 32'h0);
        chk("unfl_set_clr", 32'(UNFL), 32'h1);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 32'h0);

        // VRSTART with 100 words and a simultaneous write and read.
        for (int i = 0; i < 100; i++) wr($urandom, 0);
        cyc(0, 1, 1, 1, 1, 0, 1, 0, 32'h0012_3456);
        rd();
        chk("vrstart_unfl", 32'(UNFL), 32'h1);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 32'h0);

        // DISPON low flushes and blocks output.
        for (int i = 0; i < 4; i++) wr($urandom, 0);
        cyc(0, 0, 0, 1, 1, 0, 1, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        chk("dispon_low_wready", 32'(BUF_WREADY), 32'h0);
        idle();
        rd();
        chk("dispon_flush_unfl", 32'(UNFL), 32'h1);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 32'h0);

        // Reset mid-burst discards stored data.
        for (int i = 0; i < 4; i++) wr($urandom, 0);
        cyc(1, 1, 0, 1, 1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) wr(32'h00A0_B0C0 + i, i == 2);
        for (int i = 0; i < 4; i++) rd();
        chk("post_rst_unfl", 32'(UNFL), 32'h1);
        chk("scoreboard_empty", 32'(exp_pix.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
